commit_trap_ctrl: RTL and testbench

Commit-stage trap/squash sequencer beside the ROB. Takes the commit-head exception, pending interrupt and oldest-mispredict summaries, and stalls commit. It reads the FTQ start address, computes the trap return PC (epc), and pulses a CSR trap update. It then issues a single registered pipeline squash: branch npc for a mispredict, tvec for a trap.

---
 rtl/commit_trap_ctrl_pkg.sv | 33 +++
 rtl/commit_trap_ctrl_if.sv | 57 +++++
 rtl/commit_trap_ctrl_epc_calc.sv | 33 +++
 rtl/commit_trap_ctrl.sv | 133 +++++++++++++
 tb/tb_commit_trap_ctrl.sv | 354 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/commit_trap_ctrl_pkg.sv
// Shared types and widths for the commit-stage trap/squash sequencer.
// TRAP_VECTORED_EN selects vectored interrupt targets (see epc_calc).
package commit_trap_ctrl_pkg;

    localparam int XLEN     = 64;
    localparam int FTQIDX_W = 4;
    localparam int FTQOFS_W = 4;
    localparam int CAUSE_W  = 6;

    typedef enum logic [2:0] {
        IDLE,
        INT_WAIT,
        FTQ_RD,
        EPC,
        SQUASH
    } trap_ctrl_state_t;

    typedef struct packed {
        logic [CAUSE_W-1:0]  cause;
        logic                is_intr;
        logic [FTQIDX_W-1:0] ftq_idx;
        logic [FTQOFS_W-1:0] ftqOffset;
        logic                isRVC;
    } trapLatch_t;

    typedef struct packed {
        logic            vld;
        logic            dueToBranch;
        logic            branch_taken;
        logic [XLEN-1:0] pc;
    } squashInfo_t;

endpackage

// File: rtl/commit_trap_ctrl_if.sv
// ROB / FTQ / CSR / frontend signal bundle seen by the trap sequencer.
// slave is the sequencer's view, master is the surrounding pipeline's view.
interface commit_trap_ctrl_if;
    import commit_trap_ctrl_pkg::*;

    logic                i_except_vld;
    logic [CAUSE_W-1:0]  i_except_cause;
    logic [FTQIDX_W-1:0] i_except_ftq_idx;
    logic [FTQOFS_W-1:0] i_except_ftqOffset;
    logic                i_intr_pending;
    logic [CAUSE_W-1:0]  i_intr_cause;
    logic                i_commit_idle;
    logic [FTQIDX_W-1:0] i_last_ftq_idx;
    logic [FTQOFS_W-1:0] i_last_ftqOffset;
    logic                i_last_isRVC;
    logic                i_mispred_vld;
    logic                i_mispred_taken;
    logic [XLEN-1:0]     i_mispred_npc;
    logic                o_commit_stall;
    logic [FTQIDX_W-1:0] o_ftq_idx;
    logic [XLEN-1:0]     i_ftq_startAddress;
    logic [XLEN-1:0]     i_tvec;
    logic                o_csr_trap_vld;
    logic [XLEN-1:0]     o_csr_epc;
    logic [CAUSE_W-1:0]  o_csr_cause;
    logic                o_csr_is_intr;
    logic                o_squash_vld;
    logic                o_squash_dueToBranch;
    logic                o_squash_branch_taken;
    logic [XLEN-1:0]     o_squash_pc;
    logic                o_wait_timeout;

    modport slave (
        input  i_except_vld, i_except_cause, i_except_ftq_idx, i_except_ftqOffset,
        input  i_intr_pending, i_intr_cause, i_commit_idle,
        input  i_last_ftq_idx, i_last_ftqOffset, i_last_isRVC,
        input  i_mispred_vld, i_mispred_taken, i_mispred_npc,
        input  i_ftq_startAddress, i_tvec,
        output o_commit_stall, o_ftq_idx,
        output o_csr_trap_vld, o_csr_epc, o_csr_cause, o_csr_is_intr,
        output o_squash_vld, o_squash_dueToBranch, o_squash_branch_taken, o_squash_pc,
        output o_wait_timeout
    );

    modport master (
        output i_except_vld, i_except_cause, i_except_ftq_idx, i_except_ftqOffset,
        output i_intr_pending, i_intr_cause, i_commit_idle,
        output i_last_ftq_idx, i_last_ftqOffset, i_last_isRVC,
        output i_mispred_vld, i_mispred_taken, i_mispred_npc,
        output i_ftq_startAddress, i_tvec,
        input  o_commit_stall, o_ftq_idx,
        input  o_csr_trap_vld, o_csr_epc, o_csr_cause, o_csr_is_intr,
        input  o_squash_vld, o_squash_dueToBranch, o_squash_branch_taken, o_squash_pc,
        input  o_wait_timeout
    );

endinterface

// File: rtl/commit_trap_ctrl_epc_calc.sv
// Trap return PC and trap target arithmetic (purely combinational).
// TRAP_VECTORED_EN adds cause*4 to the base for vectored interrupts.
module epc_calc
    import commit_trap_ctrl_pkg::*;
(
    input  logic [XLEN-1:0]     start_addr,
    input  logic [FTQOFS_W-1:0] ftq_offset,
    input  logic                is_rvc,
    input  logic                is_intr,
    input  logic [CAUSE_W-1:0]  cause,
    input  logic [XLEN-1:0]     tvec,
    output logic [XLEN-1:0]     epc,
    output logic [XLEN-1:0]     vec_pc
);

    logic [XLEN-1:0] inst_pc;
    logic [XLEN-1:0] tvec_base;

    // Offset counts halfwords; an interrupt returns past the last committed inst.
    assign inst_pc   = start_addr + (XLEN'(ftq_offset) << 1);
    assign epc       = is_intr ? inst_pc + (is_rvc ? XLEN'(2) : XLEN'(4)) : inst_pc;
    assign tvec_base = {tvec[XLEN-1:2], 2'b00};

`ifdef TRAP_VECTORED_EN
    assign vec_pc = (is_intr && tvec[1:0] == 2'b01) ? tvec_base + (XLEN'(cause) << 2)
                                                    : tvec_base;
`else
    logic unused_vec_bits;
    assign unused_vec_bits = ^{cause, tvec[1:0]};
    assign vec_pc          = tvec_base;
`endif

endmodule

// File: rtl/commit_trap_ctrl.sv
// Commit-stage trap/squash sequencer: stalls commit, reads the FTQ, pulses the
// CSR trap update, then issues one registered squash. TRAP_VECTORED_EN: see epc_calc.
module commit_trap_ctrl
    import commit_trap_ctrl_pkg::*;
#(
    parameter int INTWAIT_MAX = 64
) (
    input  logic              clk,
    input  logic              rst,
    commit_trap_ctrl_if.slave bus
);

    localparam int CNT_W = $clog2(INTWAIT_MAX + 1);

    trap_ctrl_state_t  state_q, state_d;
    trapLatch_t        latch_q, latch_d;
    squashInfo_t       squash_q, squash_d;
    logic              stall_q, stall_d;
    logic [XLEN-1:0]   start_q, start_d;
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic              timeout_q, timeout_d;
    logic [XLEN-1:0]   epc;
    logic [XLEN-1:0]   vec_pc;
    logic              csr_fire;

    epc_calc u_epc_calc (
        .start_addr (start_q),
        .ftq_offset (latch_q.ftqOffset),
        .is_rvc     (latch_q.isRVC),
        .is_intr    (latch_q.is_intr),
        .cause      (latch_q.cause),
        .tvec       (bus.i_tvec),
        .epc        (epc),
        .vec_pc     (vec_pc)
    );

    always_comb begin
        // NOTE: every signal gets a default before the case so no path infers a latch.
        state_d    = state_q;
        latch_d    = latch_q;
        squash_d   = '0;
        stall_d    = stall_q;
        start_d    = start_q;
        wait_cnt_d = wait_cnt_q;
        timeout_d  = timeout_q;

        unique case (state_q)
            IDLE: begin
                if (bus.i_except_vld) begin
                    latch_d = '{cause: bus.i_except_cause, is_intr: 1'b0,
                                ftq_idx: bus.i_except_ftq_idx,
                                ftqOffset: bus.i_except_ftqOffset, isRVC: 1'b0};
                    stall_d = 1'b1;
                    state_d = FTQ_RD;
                end else if (bus.i_intr_pending) begin
                    stall_d = 1'b1;
                    state_d = INT_WAIT;
                end else if (bus.i_mispred_vld) begin
                    squash_d = '{vld: 1'b1, dueToBranch: 1'b1,
                                 branch_taken: bus.i_mispred_taken, pc: bus.i_mispred_npc};
                end
            end
            INT_WAIT: begin
                if (wait_cnt_q != CNT_W'(INTWAIT_MAX)) wait_cnt_d = wait_cnt_q + CNT_W'(1);
                if (wait_cnt_d == CNT_W'(INTWAIT_MAX)) timeout_d = 1'b1;
                // Commit must drain before the return PC of the last inst is known.
                if (bus.i_commit_idle) begin
                    latch_d = '{cause: bus.i_intr_cause, is_intr: 1'b1,
                                ftq_idx: bus.i_last_ftq_idx,
                                ftqOffset: bus.i_last_ftqOffset, isRVC: bus.i_last_isRVC};
                    state_d = FTQ_RD;
                end else if (!bus.i_intr_pending) begin
                    stall_d = 1'b0;
                    state_d = IDLE;
                end
            end
            FTQ_RD: begin
                start_d = bus.i_ftq_startAddress;
                state_d = EPC;
            end
            EPC: begin
                squash_d = '{vld: 1'b1, dueToBranch: 1'b0, branch_taken: 1'b0, pc: vec_pc};
                state_d  = SQUASH;
            end
            SQUASH: begin
                stall_d = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (state_d == IDLE) begin
            wait_cnt_d = '0;
            timeout_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            latch_q    <= '0;
            squash_q   <= '0;
            stall_q    <= 1'b0;
            start_q    <= '0;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values.
            state_q    <= state_d;
            latch_q    <= latch_d;
            squash_q   <= squash_d;
            stall_q    <= stall_d;
            start_q    <= start_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    // The CSR update is gated by EPC, so it can never overlap the squash pulse.
    assign csr_fire                  = (state_q == EPC);
    assign bus.o_commit_stall        = stall_q;
    assign bus.o_ftq_idx             = latch_q.ftq_idx;
    assign bus.o_csr_trap_vld        = csr_fire;
    assign bus.o_csr_epc             = csr_fire ? epc : '0;
    assign bus.o_csr_cause           = csr_fire ? latch_q.cause : '0;
    assign bus.o_csr_is_intr         = csr_fire & latch_q.is_intr;
    assign bus.o_squash_vld          = squash_q.vld;
    assign bus.o_squash_dueToBranch  = squash_q.dueToBranch;
    assign bus.o_squash_branch_taken = squash_q.branch_taken;
    assign bus.o_squash_pc           = squash_q.pc;
    assign bus.o_wait_timeout        = timeout_q;

endmodule

// File: tb/tb_commit_trap_ctrl.sv
// Self-checking bench for commit_trap_ctrl: directed table, hand sequences, random
// scenarios against a per-transaction timeline model. Honors TRAP_VECTORED_EN.
module tb_commit_trap_ctrl;
    import commit_trap_ctrl_pkg::*;

    localparam int INTWAIT_MAX = 64;
`ifdef TRAP_VECTORED_EN
    localparam bit VECTORED = 1'b1;
`else
    localparam bit VECTORED = 1'b0;
`endif

    typedef enum int {K_MISPRED, K_EXCEPT, K_INTR, K_INTR_DROP} kind_e;

    typedef struct {
        kind_e               kind;
        bit                  with_mispred;
        logic [CAUSE_W-1:0]  cause;
        logic [FTQIDX_W-1:0] idx;
        logic [FTQOFS_W-1:0] ofs;
        bit                  rvc;
        logic [XLEN-1:0]     start;
        logic [XLEN-1:0]     tvec;
        logic [XLEN-1:0]     npc;
        bit                  taken;
        int                  wait_cyc;
        logic [XLEN-1:0]     exp_epc;
        logic [XLEN-1:0]     exp_pc;
    } vec_t;

    typedef struct packed {
        logic                stall;
        logic [FTQIDX_W-1:0] ftq_idx;
        logic                csr_vld;
        logic [XLEN-1:0]     epc;
        logic [CAUSE_W-1:0]  cause;
        logic                is_intr;
        logic                sq_vld;
        logic                sq_br;
        logic                sq_taken;
        logic [XLEN-1:0]     sq_pc;
        logic                timeout;
    } out_t;

    logic clk;
    logic rst;
    commit_trap_ctrl_if bus ();

    commit_trap_ctrl #(.INTWAIT_MAX(INTWAIT_MAX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int n_checks = 0;
    int n_fail   = 0;
    logic [FTQIDX_W-1:0] ftq_hold = '0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic out_t sample();
        out_t o;
        o.stall    = bus.o_commit_stall;
        o.ftq_idx  = bus.o_ftq_idx;
        o.csr_vld  = bus.o_csr_trap_vld;
        o.epc      = bus.o_csr_epc;
        o.cause    = bus.o_csr_cause;
        o.is_intr  = bus.o_csr_is_intr;
        o.sq_vld   = bus.o_squash_vld;
        o.sq_br    = bus.o_squash_dueToBranch;
        o.sq_taken = bus.o_squash_branch_taken;
        o.sq_pc    = bus.o_squash_pc;
        o.timeout  = bus.o_wait_timeout;
        return o;
    endfunction

    task automatic check_out(input string name, input out_t exp);
        out_t act;
        act = sample();
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic out_t idle_out();
        out_t o;
        o = '0;
        o.ftq_idx = ftq_hold;
        return o;
    endfunction

    function automatic out_t stall_out();
        out_t o;
        o = idle_out();
        o.stall = 1'b1;
        return o;
    endfunction

    // Reference arithmetic: return PC and trap target from the architectural rules.
    function automatic logic [XLEN-1:0] model_epc(input logic [XLEN-1:0] start,
                                                  input int unsigned ofs, input bit rvc,
                                                  input bit intr);
        logic [XLEN-1:0] r;
        r = start + XLEN'(2 * ofs);
        if (intr) r = r + (rvc ? XLEN'(2) : XLEN'(4));
        return r;
    endfunction

    function automatic logic [XLEN-1:0] model_tvec(input logic [XLEN-1:0] tvec,
                                                   input int unsigned cause, input bit intr);
        logic [XLEN-1:0] r;
        r = tvec & ~XLEN'(3);
        if (VECTORED && intr && tvec[1:0] == 2'd1) r = r + XLEN'(4 * cause);
        return r;
    endfunction

    function automatic vec_t mk_trap(input kind_e k, input bit mis, input int unsigned cause,
                                     input int unsigned idx, input int unsigned ofs,
                                     input bit rvc, input logic [XLEN-1:0] start,
                                     input logic [XLEN-1:0] tvec, input int w,
                                     input logic [XLEN-1:0] epc, input logic [XLEN-1:0] pc);
        vec_t v;
        v.kind = k;  v.with_mispred = mis;  v.cause = CAUSE_W'(cause);
        v.idx = FTQIDX_W'(idx);  v.ofs = FTQOFS_W'(ofs);  v.rvc = rvc;
        v.start = start;  v.tvec = tvec;  v.npc = '0;  v.taken = 1'b0;
        v.wait_cyc = w;  v.exp_epc = epc;  v.exp_pc = pc;
        return v;
    endfunction

    function automatic vec_t mk_mispred(input bit taken, input logic [XLEN-1:0] npc);
        vec_t v;
        v = mk_trap(K_MISPRED, 1'b0, 0, 0, 0, 1'b0, '0, '0, 0, '0, npc);
        v.taken = taken;
        v.npc   = npc;
        return v;
    endfunction

    task automatic clear_inputs();
        bus.i_except_vld = 1'b0;  bus.i_except_cause = '0;
        bus.i_except_ftq_idx = '0;  bus.i_except_ftqOffset = '0;
        bus.i_intr_pending = 1'b0;  bus.i_intr_cause = '0;  bus.i_commit_idle = 1'b0;
        bus.i_last_ftq_idx = '0;  bus.i_last_ftqOffset = '0;  bus.i_last_isRVC = 1'b0;
        bus.i_mispred_vld = 1'b0;  bus.i_mispred_taken = 1'b0;  bus.i_mispred_npc = '0;
        bus.i_ftq_startAddress = '0;  bus.i_tvec = '0;
    endtask

    task automatic run_vec(input vec_t v, input bit noise, input string tag);
        out_t e;
        bit is_intr;
        is_intr = (v.kind == K_INTR);
        bus.i_ftq_startAddress = v.start;
        bus.i_tvec = v.tvec;
        case (v.kind)
            K_MISPRED: begin
                bus.i_mispred_vld = 1'b1;  bus.i_mispred_taken = v.taken;  bus.i_mispred_npc = v.npc;
                tick();
                bus.i_mispred_vld = 1'b0;
                e = idle_out();  e.sq_vld = 1'b1;  e.sq_br = 1'b1;
                e.sq_taken = v.taken;  e.sq_pc = v.exp_pc;
                check_out({tag, " branch squash"}, e);
                tick();
                check_out({tag, " branch squash ends"}, idle_out());
            end
            K_INTR_DROP: begin
                bus.i_intr_pending = 1'b1;  bus.i_intr_cause = v.cause;  bus.i_commit_idle = 1'b0;
                tick();
                check_out({tag, " intr stall"}, stall_out());
                repeat (v.wait_cyc) begin
                    tick();
                    check_out({tag, " intr waiting"}, stall_out());
                end
                bus.i_intr_pending = 1'b0;
                tick();
                check_out({tag, " intr dropped"}, idle_out());
            end
            default: begin
                bus.i_mispred_vld = v.with_mispred;  bus.i_mispred_taken = 1'b1;
                bus.i_mispred_npc = {$urandom, $urandom};
                if (is_intr) begin
                    bus.i_intr_pending = 1'b1;  bus.i_intr_cause = v.cause;  bus.i_commit_idle = 1'b0;
                    tick();
                    bus.i_mispred_vld = 1'b0;
                    check_out({tag, " intr stall"}, stall_out());
                    repeat (v.wait_cyc) begin
                        if (noise) begin
                            bus.i_except_vld = 1'($urandom);  bus.i_mispred_vld = 1'($urandom);
                            bus.i_last_ftq_idx = FTQIDX_W'($urandom);
                            bus.i_last_ftqOffset = FTQOFS_W'($urandom);
                        end
                        tick();
                        check_out({tag, " intr waiting"}, stall_out());
                    end
                    bus.i_except_vld = 1'b0;  bus.i_mispred_vld = 1'b0;
                    bus.i_commit_idle = 1'b1;  bus.i_last_ftq_idx = v.idx;
                    bus.i_last_ftqOffset = v.ofs;  bus.i_last_isRVC = v.rvc;
                    tick();
                    bus.i_commit_idle = 1'b0;  bus.i_intr_pending = 1'b0;
                end else begin
                    bus.i_except_vld = 1'b1;  bus.i_except_cause = v.cause;
                    bus.i_except_ftq_idx = v.idx;  bus.i_except_ftqOffset = v.ofs;
                    tick();
                    bus.i_except_vld = 1'b0;  bus.i_mispred_vld = 1'b0;
                end
                ftq_hold = v.idx;
                check_out({tag, " trap stall, ftq read"}, stall_out());
                if (noise) begin
                    bus.i_except_vld = 1'($urandom);  bus.i_mispred_vld = 1'($urandom);
                    bus.i_intr_pending = 1'($urandom);
                end
                tick();
                e = stall_out();  e.csr_vld = 1'b1;  e.epc = v.exp_epc;
                e.cause = v.cause;  e.is_intr = is_intr;
                check_out({tag, " csr trap pulse"}, e);
                tick();
                e = stall_out();  e.sq_vld = 1'b1;  e.sq_pc = v.exp_pc;
                check_out({tag, " trap squash"}, e);
                bus.i_except_vld = 1'b0;  bus.i_mispred_vld = 1'b0;  bus.i_intr_pending = 1'b0;
                tick();
                check_out({tag, " trap done"}, idle_out());
            end
        endcase
    endtask

    initial begin
        vec_t table_v[7];
        vec_t rv;
        out_t e;

        table_v[0] = mk_mispred(1'b1, 64'h0000_0000_8000_0100);
        table_v[1] = mk_trap(K_EXCEPT, 1'b0, 2, 3, 5, 1'b0, 64'h1000, 64'h2000, 0,
                             64'h100A, 64'h2000);
        table_v[2] = mk_trap(K_INTR, 1'b0, 11, 6, 2, 1'b1, 64'h4000, 64'h3000, 3,
                             64'h4006, 64'h3000);
        table_v[3] = mk_trap(K_EXCEPT, 1'b1, 13, 9, 15, 1'b1, 64'hFFFF_FFFF_FFFF_FFF0,
                             64'h8000_0003, 0, 64'h000E, 64'h8000_0000);
        table_v[4] = mk_trap(K_INTR, 1'b1, 7, 1, 0, 1'b0, 64'h5000, 64'h2001, 0,
                             64'h5004, VECTORED ? 64'h201C : 64'h2000);
        table_v[5] = mk_mispred(1'b0, 64'h1234_5678_9ABC_DEF0);
        table_v[6] = mk_trap(K_INTR, 1'b0, 63, 15, 15, 1'b0, 64'h7FF0, 64'h4001, 1,
                             64'h8012, VECTORED ? 64'h40FC : 64'h4000);

        clear_inputs();
        rst = 1'b0;
        #2;
        check_out("reset state", idle_out());
        tick();
        tick();
        rst = 1'b1;
        tick();
        check_out("idle after reset", idle_out());

        for (int i = 0; i < 7; i++) run_vec(table_v[i], 1'b0, $sformatf("vec%0d", i));

        // Interrupt withdrawn while waiting; a mispredict in that window is ignored.
        bus.i_intr_pending = 1'b1;  bus.i_intr_cause = 6'd3;
        tick();
        check_out("drop enter", stall_out());
        bus.i_mispred_vld = 1'b1;  bus.i_mispred_npc = 64'hDEAD_0000;
        repeat (4) tick();
        check_out("drop mispred ignored", stall_out());
        bus.i_mispred_vld = 1'b0;  bus.i_intr_pending = 1'b0;
        tick();
        check_out("drop released", idle_out());
        tick();
        check_out("drop no pulses", idle_out());

        // Watchdog boundary, then sticky timeout through a late trap.
        bus.i_intr_pending = 1'b1;  bus.i_intr_cause = 6'd9;
        bus.i_ftq_startAddress = 64'h9000;  bus.i_tvec = 64'hA000;
        tick();
        check_out("timeout enter", stall_out());
        repeat (INTWAIT_MAX - 1) tick();
        check_out("timeout one short", stall_out());
        tick();
        e = stall_out();  e.timeout = 1'b1;
        check_out("timeout asserted", e);
        repeat (5) tick();
        check_out("timeout saturated", e);
        bus.i_commit_idle = 1'b1;  bus.i_last_ftq_idx = 4'd12;
        bus.i_last_ftqOffset = 4'd3;  bus.i_last_isRVC = 1'b0;
        tick();
        bus.i_commit_idle = 1'b0;  bus.i_intr_pending = 1'b0;
        ftq_hold = 4'd12;
        e = stall_out();  e.timeout = 1'b1;
        check_out("timeout held in ftq read", e);
        tick();
        e = stall_out();  e.timeout = 1'b1;  e.csr_vld = 1'b1;
        e.epc = 64'h900A;  e.cause = 6'd9;  e.is_intr = 1'b1;
        check_out("timeout trap csr", e);
        tick();
        e = stall_out();  e.timeout = 1'b1;  e.sq_vld = 1'b1;  e.sq_pc = 64'hA000;
        check_out("timeout trap squash", e);
        tick();
        check_out("timeout cleared in idle", idle_out());

        // Reset asserted mid-sequence, while the CSR pulse is up.
        bus.i_except_vld = 1'b1;  bus.i_except_cause = 6'd5;
        bus.i_except_ftq_idx = 4'd5;  bus.i_except_ftqOffset = 4'd1;
        bus.i_ftq_startAddress = 64'h100;  bus.i_tvec = 64'h800;
        tick();
        bus.i_except_vld = 1'b0;
        ftq_hold = 4'd5;
        tick();
        e = stall_out();  e.csr_vld = 1'b1;  e.epc = 64'h102;  e.cause = 6'd5;
        check_out("reset seq csr pulse", e);
        rst = 1'b0;
        #1;
        ftq_hold = '0;
        check_out("reset in epc clears outputs", idle_out());
        tick();
        rst = 1'b1;
        tick();
        check_out("reset seq no squash", idle_out());
        tick();
        check_out("reset seq stays idle", idle_out());

        for (int n = 0; n < 300; n++) begin
            rv.kind = kind_e'($urandom_range(0, 3));
            rv.with_mispred = 1'($urandom);
            rv.cause = CAUSE_W'($urandom);
            rv.idx = FTQIDX_W'($urandom);
            rv.ofs = FTQOFS_W'($urandom);
            rv.rvc = 1'($urandom);
            rv.start = {$urandom, $urandom};
            rv.tvec = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 1) rv.tvec[1:0] = 2'd1;
            rv.npc = {$urandom, $urandom};
            rv.taken = 1'($urandom);
            rv.wait_cyc = int'($urandom_range(0, 8));
            rv.exp_epc = model_epc(rv.start, rv.ofs, rv.rvc, rv.kind == K_INTR);
            rv.exp_pc = (rv.kind == K_MISPRED) ? rv.npc
                                               : model_tvec(rv.tvec, rv.cause, rv.kind == K_INTR);
            run_vec(rv, 1'b1, $sformatf("rand%0d", n));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
